// File: rtl/mdio_pkg.sv
// Shared MDIO frame constants, field geometry and receiver state encoding.
package mdio_pkg;

  localparam logic [1:0] ST_C22    = 2'b01;
  localparam logic [1:0] ST_C45    = 2'b00;

  localparam logic [1:0] C22_WR    = 2'b01;
  localparam logic [1:0] C22_RD    = 2'b10;
  localparam logic [1:0] C45_ADDR  = 2'b00;
  localparam logic [1:0] C45_WR    = 2'b01;
  localparam logic [1:0] C45_RD    = 2'b11;
  localparam logic [1:0] C45_RDINC = 2'b10;

  localparam int unsigned PHYAD_LEN = 5;
  localparam int unsigned REGAD_LEN = 5;
  localparam int unsigned TA_LEN    = 2;
  localparam int unsigned DATA_LEN  = 16;
  localparam int unsigned FRAME_LEN = 4 + PHYAD_LEN + REGAD_LEN + TA_LEN + DATA_LEN;

  // Frame bit index (bit 0 = first ST bit) of the last bit of each field
  localparam int unsigned POS_OP_END  = 3;
  localparam int unsigned POS_PHY_END = POS_OP_END + PHYAD_LEN;
  localparam int unsigned POS_REG_END = POS_PHY_END + REGAD_LEN;
  localparam int unsigned POS_TA_END  = POS_REG_END + TA_LEN;
  localparam int unsigned POS_LAST    = FRAME_LEN - 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
  } state_t;

endpackage

// File: rtl/mdio_slave_param_rd_shifter.sv
// Read-data serialiser: parks the line at 1, drives the TA zero, then shifts 16 bits MSB first.
module mdio_rd_shifter
  import mdio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic                drive_zero,
  input  logic [DATA_LEN-1:0] load_data,
  output logic                mdio_in,
  output logic                empty
);

  logic [DATA_LEN-1:0] sr;
  logic [4:0]          cnt;

  // load presents the MSB immediately; cnt tracks bits still to present
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      cnt     <= '0;
      mdio_in <= 1'b1;
      empty   <= 1'b1;
    end else if (load) begin
      mdio_in <= load_data[DATA_LEN-1];
      sr      <= {load_data[DATA_LEN-2:0], 1'b0};
      cnt     <= 5'(DATA_LEN - 1);
      empty   <= 1'b0;
    end else if (drive_zero) begin
      mdio_in <= 1'b0;
    end else if (shift) begin
      if (cnt != 5'd0) begin
        mdio_in <= sr[DATA_LEN-1];
        sr      <= {sr[DATA_LEN-2:0], 1'b0};
        cnt     <= cnt - 5'd1;
        empty   <= (cnt == 5'd1);
      end else begin
        mdio_in <= 1'b1;
        empty   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdio_slave_param.sv
// PHY-side MDIO receiver: Clause 22/45 decode, address filter, register strobes, read serialiser.
module mdio_slave_param
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter bit          C45_EN       = 1'b1,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              MDC,
  input  logic              RESET,
  input  logic              MDIO_OUT,
  input  logic              MDIO_OE,
  input  logic [15:0]       RD_DATA,
  output logic              MDIO_IN,
  output logic              MDIO_IN_EN,
  output logic [ADDR_W-1:0] ADDR,
  output logic [4:0]        DEVAD,
  output logic [15:0]       WR_DATA,
  output logic              WR_STB,
  output logic              RD_STB,
  output logic              MDIO_DONE,
  output logic              ERR
);

  localparam int unsigned PRE_W = (PREAMBLE_LEN > 0) ? $clog2(PREAMBLE_LEN + 1) : 1;

  state_t            state;
  logic [PRE_W-1:0]  pre_cnt;
  logic [4:0]        pos;
  logic [15:0]       sh;
  logic              is_c45, is_rd, is_addr, is_inc, phy_ok;
  logic              commit_wr, commit_addr;
  logic [ADDR_W-1:0] c45_addr;

  logic [15:0] sh_next;
  logic [1:0]  op_c;
  logic [4:0]  field_c;
  logic        abort_c, sh_load, sh_zero, sh_shift, sh_empty;

  assign sh_next  = {sh[14:0], MDIO_OUT};
  assign op_c     = sh_next[1:0];
  assign field_c  = sh_next[4:0];
  assign abort_c  = !MDIO_OE && ((state inside {S_ST2, S_OP, S_PHYAD, S_REGAD, S_WDATA}) ||
                                 (state == S_TA && !is_rd));
  assign sh_zero  = (state == S_TA) && is_rd && (pos == 5'(POS_REG_END + 1));
  assign sh_load  = (state == S_TA) && is_rd && (pos == 5'(POS_TA_END));
  assign sh_shift = (state == S_RDATA);

  mdio_rd_shifter u_rd_shifter (
    .clk        (MDC),
    .rst        (RESET),
    .load       (sh_load),
    .shift      (sh_shift),
    .drive_zero (sh_zero),
    .load_data  (RD_DATA),
    .mdio_in    (MDIO_IN),
    .empty      (sh_empty)
  );

  always_ff @(posedge MDC) begin
    if (RESET) begin
      state       <= S_IDLE;
      pre_cnt     <= '0;
      pos         <= '0;
      sh          <= '0;
      is_c45      <= 1'b0;
      is_rd       <= 1'b0;
      is_addr     <= 1'b0;
      is_inc      <= 1'b0;
      phy_ok      <= 1'b0;
      commit_wr   <= 1'b0;
      commit_addr <= 1'b0;
      c45_addr    <= '0;
      MDIO_IN_EN  <= 1'b0;
      ADDR        <= '0;
      DEVAD       <= '0;
      WR_DATA     <= '0;
      WR_STB      <= 1'b0;
      RD_STB      <= 1'b0;
      MDIO_DONE   <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      WR_STB      <= 1'b0;
      RD_STB      <= 1'b0;
      MDIO_DONE   <= 1'b0;
      ERR         <= 1'b0;
      commit_wr   <= 1'b0;
      commit_addr <= 1'b0;

      // Write-type frames complete one edge after their last data bit
      if (commit_wr) begin
        WR_DATA   <= sh;
        WR_STB    <= 1'b1;
        MDIO_DONE <= 1'b1;
      end
      if (commit_addr) begin
        c45_addr  <= ADDR_W'(sh);
        MDIO_DONE <= 1'b1;
      end

      if (abort_c) begin
        state      <= S_IDLE;
        pre_cnt    <= '0;
        ERR        <= 1'b1;
        MDIO_IN_EN <= 1'b0;
      end else begin
        if (state != S_IDLE) begin
          pos <= pos + 5'd1;
          sh  <= sh_next;
        end
        case (state)
          S_IDLE: if (MDIO_OE) begin
            if (MDIO_OUT) begin
              if (pre_cnt != PRE_W'(PREAMBLE_LEN)) pre_cnt <= pre_cnt + PRE_W'(1);
            end else if (pre_cnt == PRE_W'(PREAMBLE_LEN)) begin
              state   <= S_ST2;
              pos     <= 5'd1;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= '0;
            end
          end
          S_ST2: begin
            if ({1'b0, MDIO_OUT} == ST_C22) begin
              is_c45 <= 1'b0;
              state  <= S_OP;
            end else if (C45_EN && ({1'b0, MDIO_OUT} == ST_C45)) begin
              is_c45 <= 1'b1;
              state  <= S_OP;
            end else begin
              ERR   <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_OP: if (pos == 5'(POS_OP_END)) begin
            state <= S_PHYAD;
            if (is_c45) begin
              unique case (op_c)
                C45_ADDR:  {is_rd, is_addr, is_inc} <= 3'b010;
                C45_WR:    {is_rd, is_addr, is_inc} <= 3'b000;
                C45_RD:    {is_rd, is_addr, is_inc} <= 3'b100;
                C45_RDINC: {is_rd, is_addr, is_inc} <= 3'b101;
              endcase
            end else begin
              {is_addr, is_inc} <= 2'b00;
              case (op_c)
                C22_WR:  is_rd <= 1'b0;
                C22_RD:  is_rd <= 1'b1;
                default: begin
                  is_rd <= 1'b0;
                  ERR   <= 1'b1;
                  state <= S_SKIP;
                end
              endcase
            end
          end
          S_PHYAD: if (pos == 5'(POS_PHY_END)) begin
            phy_ok <= (field_c == PHY_ADDR);
            state  <= S_REGAD;
          end
          // Addresses are presented with RD_STB during the first TA bit
          S_REGAD: if (pos == 5'(POS_REG_END)) begin
            if (!phy_ok) begin
              state <= S_SKIP;
            end else begin
              state <= S_TA;
              if (is_c45) begin
                DEVAD <= field_c;
                if (!is_addr) ADDR <= c45_addr;
              end else begin
                DEVAD <= '0;
                ADDR  <= ADDR_W'(field_c);
              end
              RD_STB <= is_rd;
            end
          end
          S_TA: begin
            if (is_rd) begin
              if (pos == 5'(POS_REG_END + 1)) MDIO_IN_EN <= 1'b1;
              else                            state      <= S_RDATA;
            end else if (pos == 5'(POS_REG_END + 1)) begin
              if (!MDIO_OUT) begin
                ERR   <= 1'b1;
                state <= S_SKIP;
              end
            end else if (MDIO_OUT) begin
              ERR   <= 1'b1;
              state <= S_SKIP;
            end else begin
              state <= S_WDATA;
            end
          end
          S_WDATA: if (pos == 5'(POS_LAST)) begin
            state       <= S_IDLE;
            commit_wr   <= !is_addr;
            commit_addr <= is_addr;
          end
          S_RDATA: if (sh_empty) begin
            state      <= S_IDLE;
            MDIO_IN_EN <= 1'b0;
            MDIO_DONE  <= 1'b1;
            if (is_inc) c45_addr <= c45_addr + ADDR_W'(1);
          end
          S_SKIP: if (pos == 5'(POS_LAST)) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_slave_param.sv
// Directed self-checking bench for mdio_slave_param (default instance plus a no-preamble instance).
module tb_mdio_slave_param;

  logic        MDC = 1'b0;
  logic        RESET = 1'b1;
  logic        MDIO_OUT = 1'b1;
  logic        MDIO_OE = 1'b1;
  logic [15:0] RD_DATA = 16'h0000;
  logic        MDIO_IN, MDIO_IN_EN, WR_STB, RD_STB, MDIO_DONE, ERR;
  logic [15:0] ADDR, WR_DATA;
  logic [4:0]  DEVAD;

  logic        b_mdio_in, b_en, b_wr_stb, b_rd_stb, b_done, b_err;
  logic [15:0] b_addr, b_wr_data_o;
  logic [4:0]  b_devad;

  mdio_slave_param dut (
    .MDC(MDC), .RESET(RESET), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE), .RD_DATA(RD_DATA),
    .MDIO_IN(MDIO_IN), .MDIO_IN_EN(MDIO_IN_EN), .ADDR(ADDR), .DEVAD(DEVAD), .WR_DATA(WR_DATA),
    .WR_STB(WR_STB), .RD_STB(RD_STB), .MDIO_DONE(MDIO_DONE), .ERR(ERR)
  );

  mdio_slave_param #(.PREAMBLE_LEN(0)) dut_b (
    .MDC(MDC), .RESET(RESET), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE), .RD_DATA(RD_DATA),
    .MDIO_IN(b_mdio_in), .MDIO_IN_EN(b_en), .ADDR(b_addr), .DEVAD(b_devad), .WR_DATA(b_wr_data_o),
    .WR_STB(b_wr_stb), .RD_STB(b_rd_stb), .MDIO_DONE(b_done), .ERR(b_err)
  );

  always #5 MDC = ~MDC;

  int checks = 0, passes = 0, fails = 0;
  int n_wr, n_rd, n_done, n_err, n_en, wr_done_same, rd_bit, done_bit, cur_bit, b_nwr;
  int both_cnt = 0, wrrd_cnt = 0;
  logic [15:0] wr_addr, wr_data, rd_addr, b_wr_addr, b_wr_data;
  logic [4:0]  rd_devad;
  logic [16:0] line;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                     input logic [4:0] phy, input logic [4:0] rg,
                                     input logic [1:0] ta, input logic [15:0] d);
    return {st, op, phy, rg, ta, d};
  endfunction

  task automatic clr();
    n_wr = 0; n_rd = 0; n_done = 0; n_err = 0; n_en = 0; wr_done_same = 0; b_nwr = 0;
    rd_bit = -1; done_bit = -1; line = '0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; rd_devad = '0; b_wr_addr = '0; b_wr_data = '0;
  endtask

  // Drive one bit time, then sample outputs 1 ns after the rising edge
  task automatic step(input logic b, input logic oe);
    MDIO_OUT = b;
    MDIO_OE  = oe;
    @(posedge MDC);
    #1;
    if (WR_STB) begin
      n_wr++; wr_addr = ADDR; wr_data = WR_DATA;
      if (MDIO_DONE) wr_done_same++;
    end
    if (RD_STB) begin n_rd++; rd_addr = ADDR; rd_devad = DEVAD; rd_bit = cur_bit; end
    if (MDIO_DONE) begin n_done++; done_bit = cur_bit; end
    if (ERR) n_err++;
    if (ERR && MDIO_DONE) both_cnt++;
    if (WR_STB && RD_STB) wrrd_cnt++;
    if (MDIO_IN_EN) begin n_en++; line = {line[15:0], MDIO_IN}; end
    if (b_wr_stb) begin b_nwr++; b_wr_addr = b_addr; b_wr_data = b_wr_data_o; end
  endtask

  // Read frames release the line from the first TA bit onwards
  task automatic send_frame(input int pre, input logic [31:0] f, input bit rd);
    cur_bit = -1;
    for (int i = 0; i < pre; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      cur_bit = i;
      if (rd && i >= 14) step(1'b1, 1'b0);
      else               step(f[31-i], 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      cur_bit = 32 + i;
      step(1'b1, 1'b1);
    end
  endtask

  initial begin
    clr();
    cur_bit = -1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_mdio_in", 32'(MDIO_IN), 32'd1);
    chk("rst_in_en", 32'(MDIO_IN_EN), 32'd0);
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_devad", 32'(DEVAD), 32'd0);
    chk("rst_wr_data", 32'(WR_DATA), 32'd0);
    chk("rst_strobes", 32'({WR_STB, RD_STB, MDIO_DONE, ERR}), 32'd0);
    RESET = 1'b0;

    // Clause 22 write
    clr();
    send_frame(32, mk(2'b01, 2'b01, 5'd1, 5'h04, 2'b10, 16'hA5C3), 1'b0);
    chk("c22w_wr_cnt", 32'(n_wr), 32'd1);
    chk("c22w_addr", 32'(wr_addr), 32'h0004);
    chk("c22w_data", 32'(wr_data), 32'hA5C3);
    chk("c22w_done_cnt", 32'(n_done), 32'd1);
    chk("c22w_done_with_wr", 32'(wr_done_same), 32'd1);
    chk("c22w_done_edge", 32'(done_bit), 32'd32);
    chk("c22w_no_drive", 32'(n_en), 32'd0);
    chk("c22w_no_err", 32'(n_err), 32'd0);

    // Clause 22 read
    clr();
    RD_DATA = 16'h1234;
    send_frame(32, mk(2'b01, 2'b10, 5'd1, 5'h02, 2'b11, 16'h0000), 1'b1);
    chk("c22r_rd_cnt", 32'(n_rd), 32'd1);
    chk("c22r_stb_edge", 32'(rd_bit), 32'd13);
    chk("c22r_addr", 32'(rd_addr), 32'h0002);
    chk("c22r_devad", 32'(rd_devad), 32'd0);
    chk("c22r_en_cycles", 32'(n_en), 32'd17);
    chk("c22r_line", 32'(line), 32'h01234);
    chk("c22r_done_edge", 32'(done_bit), 32'd31);
    chk("c22r_done_cnt", 32'(n_done), 32'd1);
    chk("c22r_no_wr", 32'(n_wr), 32'd0);

    // Clause 45 address, read-increment, read
    clr();
    send_frame(32, mk(2'b00, 2'b00, 5'd1, 5'd3, 2'b10, 16'hFFFF), 1'b0);
    chk("c45a_done", 32'(n_done), 32'd1);
    chk("c45a_no_wr", 32'(n_wr), 32'd0);
    clr();
    RD_DATA = 16'hBEEF;
    send_frame(32, mk(2'b00, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000), 1'b1);
    chk("c45ri_addr", 32'(rd_addr), 32'hFFFF);
    chk("c45ri_devad", 32'(rd_devad), 32'd3);
    chk("c45ri_line", 32'(line), 32'h0BEEF);
    clr();
    RD_DATA = 16'h0C45;
    send_frame(32, mk(2'b00, 2'b11, 5'd1, 5'd3, 2'b11, 16'h0000), 1'b1);
    chk("c45r_addr_wrap", 32'(rd_addr), 32'h0000);
    chk("c45r_devad", 32'(rd_devad), 32'd3);
    chk("c45r_line", 32'(line), 32'h00C45);

    // Foreign PHY address, then an immediately following valid write
    clr();
    send_frame(32, mk(2'b01, 2'b10, 5'h07, 5'h02, 2'b11, 16'h0000), 1'b1);
    chk("phy7_rd_cnt", 32'(n_rd), 32'd0);
    chk("phy7_no_drive", 32'(n_en), 32'd0);
    chk("phy7_no_err", 32'(n_err), 32'd0);
    chk("phy7_no_done", 32'(n_done), 32'd0);
    clr();
    send_frame(32, mk(2'b01, 2'b01, 5'd1, 5'h1F, 2'b10, 16'h0F0F), 1'b0);
    chk("after7_wr_cnt", 32'(n_wr), 32'd1);
    chk("after7_addr", 32'(wr_addr), 32'h001F);
    chk("after7_data", 32'(wr_data), 32'h0F0F);

    // Short preamble: ignored with 32 required, accepted with none required
    RESET = 1'b1;
    step(1'b1, 1'b1);
    RESET = 1'b0;
    clr();
    send_frame(31, mk(2'b01, 2'b01, 5'd1, 5'h06, 2'b10, 16'h1111), 1'b0);
    chk("short_pre_wr", 32'(n_wr), 32'd0);
    chk("short_pre_done", 32'(n_done), 32'd0);
    chk("short_pre_err", 32'(n_err), 32'd0);
    clr();
    send_frame(0, mk(2'b01, 2'b01, 5'd1, 5'h06, 2'b10, 16'h1111), 1'b0);
    chk("nopre_b_wr_cnt", 32'(b_nwr), 32'd1);
    chk("nopre_b_addr", 32'(b_wr_addr), 32'h0006);
    chk("nopre_b_data", 32'(b_wr_data), 32'h1111);
    chk("nopre_a_ignored", 32'(n_wr), 32'd0);

    // Bad turnaround on a write
    clr();
    send_frame(32, mk(2'b01, 2'b01, 5'd1, 5'h04, 2'b11, 16'hDEAD), 1'b0);
    chk("ta11_err", 32'(n_err), 32'd1);
    chk("ta11_no_wr", 32'(n_wr), 32'd0);
    chk("ta11_no_done", 32'(n_done), 32'd0);

    // Illegal Clause 22 opcode
    clr();
    send_frame(32, mk(2'b01, 2'b11, 5'd1, 5'h04, 2'b10, 16'h0000), 1'b0);
    chk("c22op11_err", 32'(n_err), 32'd1);
    chk("c22op11_no_done", 32'(n_done), 32'd0);

    // Controller releases the line at bit 8, then a normal read must work
    clr();
    cur_bit = -1;
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cur_bit = i;
      step(mk(2'b01, 2'b01, 5'd1, 5'h04, 2'b10, 16'h0000) >> (31 - i), (i != 8) ? 1'b1 : 1'b0);
    end
    chk("oe_drop_err", 32'(n_err), 32'd1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("oe_drop_no_done", 32'(n_done), 32'd0);
    clr();
    RD_DATA = 16'h00FF;
    send_frame(32, mk(2'b01, 2'b10, 5'd1, 5'h01, 2'b11, 16'h0000), 1'b1);
    chk("post_abort_rd", 32'(n_rd), 32'd1);
    chk("post_abort_line", 32'(line), 32'h000FF);

    // Reset at bit 20 of a read
    clr();
    RD_DATA = 16'h5A5A;
    cur_bit = -1;
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cur_bit = i;
      if (i >= 14) step(1'b1, 1'b0);
      else         step(mk(2'b01, 2'b10, 5'd1, 5'h03, 2'b11, 16'h0000) >> (31 - i), 1'b1);
    end
    RESET = 1'b1;
    cur_bit = 20;
    step(1'b1, 1'b0);
    chk("rst_mid_en", 32'(MDIO_IN_EN), 32'd0);
    chk("rst_mid_line", 32'(MDIO_IN), 32'd1);
    chk("rst_mid_addr", 32'(ADDR), 32'd0);
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    chk("rst_mid_rd_seen", 32'(n_rd), 32'd1);
    chk("rst_mid_no_done", 32'(n_done), 32'd0);
    chk("rst_mid_no_err", 32'(n_err), 32'd0);

    chk("err_done_overlap", 32'(both_cnt), 32'd0);
    chk("wr_rd_overlap", 32'(wrrd_cnt), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
